// File: rtl/lsu_subword_pkg.sv
// Shared definitions for the lsu_subword load/store sub-word unit: size codes,
// FSM state encodings, the latched request record and the alignment rule.
package lsu_subword_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [31:0] wdata;
  } req_t;

  // Size code 3 is illegal and always reported as an error.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_subword_load_ext.sv
// Combinational load lane extraction: picks the addressed byte/half out of a
// little-endian word and zero- or sign-extends it to 32 bits.
module load_ext
  import lsu_subword_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'(word >> {off, 3'b000});
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: ext = {{24{lane_b[7] & ~uns}}, lane_b};
      SZ_HALF: ext = {{16{lane_h[15] & ~uns}}, lane_h};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/lsu_subword.sv
// Load/store sub-word unit between the MEM stage and a 32-bit word memory.
// Define LSU_MEM_BE_EN to add mem_be and replace read-modify-write with byte enables.
module lsu_subword
  import lsu_subword_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef LSU_MEM_BE_EN
  ,
  output logic [3:0]        mem_be
`endif
);

  logic [1:0]  state;
  req_t        req_q;
  logic [31:0] ext;
  logic        bad;
  logic        sub_store;

  function automatic logic [31:0] merge(input logic [31:0] word, input logic [31:0] data,
                                        input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    if (size == SZ_BYTE) r[{off, 3'b000} +: 8] = data[7:0];
    else                 r[{off[1], 4'b0000} +: 16] = data[15:0];
    return r;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  load_ext u_load_ext (
    .size (req_q.size),
    .uns  (req_q.uns),
    .off  (req_q.off),
    .word (mem_rdata),
    .ext  (ext)
  );

  assign bad        = misaligned(req_size, req_addr[1:0]);
  assign sub_store  = req_we && (req_size != SZ_WORD);
  assign req_ready  = (state == ST_IDLE);
  assign mem_valid  = (state == ST_RD) || (state == ST_WR);
  assign mem_we     = (state == ST_WR);
  assign resp_valid = (state == ST_RESP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_q      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
`ifdef LSU_MEM_BE_EN
      mem_be     <= 4'b0000;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_q      <= '{we: req_we, size: req_size, uns: req_unsigned,
                            off: req_addr[1:0], wdata: req_wdata};
            mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
            resp_rdata <= '0;
            resp_err   <= bad;
`ifdef LSU_MEM_BE_EN
            // Sub-word stores go straight to WR with the data copied into every lane.
            mem_wdata  <= replicate(req_size, req_wdata);
            mem_be     <= sub_store ? lane_mask(req_size, req_addr[1:0]) : 4'b1111;
            if (bad)           state <= ST_RESP;
            else if (req_we)   state <= ST_WR;
            else               state <= ST_RD;
`else
            mem_wdata  <= req_wdata;
            if (bad)                        state <= ST_RESP;
            else if (req_we && !sub_store)  state <= ST_WR;
            else                            state <= ST_RD;
`endif
          end
        end
        ST_RD: begin
          if (mem_ready) begin
            if (req_q.we) begin
              mem_wdata <= merge(mem_rdata, req_q.wdata, req_q.size, req_q.off);
              state     <= ST_WR;
            end else begin
              resp_rdata <= ext;
              state      <= ST_RESP;
            end
          end
        end
        ST_WR: begin
          if (mem_ready) state <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
